memory_dump_unit: RTL and testbench
===================================

Name: memory_dump_unit

Overview:
- Reverse of the image loader: reads a contiguous region of physical memory back out of DRAM and emits it as a byte stream.
- Uses the same little-endian byte order the loader uses to write code/data segments.
- Sits beside the fetch stage as a second memory-bus initiator.
- Used by benches to compare a memory region byte-for-byte against a golden image.

Parameters:
- ADDR_W, 21, physical address width; matches phys_memory_address_t.
- WORD_BYTES, 8, bytes per memory-bus response word (64-bit bus).
- DATA_W, 64, response data width; must equal 8*WORD_BYTES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address; must be WORD_BYTES-aligned.
- byte_count  in  ADDR_W  number of bytes to emit.
- busy  out  1  high from the cycle after an accepted start until the cycle DONE is entered.
- done  out  1  one-cycle pulse when a dump completes.
- error  out  1  one-cycle pulse when start is rejected for misalignment.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  request accepted by the bus.
- mem_req_addr  out  ADDR_W  word-aligned read address.
- mem_resp_valid  in  1  read data valid; single cycle, no backpressure.
- mem_resp_data  in  DATA_W  read word.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  consumer ready.
- out_data  out  8  stream byte.
- out_last  out  1  marks the final byte of the dump.

Behaviour:
- Reset (asynchronous): state=IDLE; every output 0; internal address, remaining count, byte index and word buffer cleared. Reset mid-dump abandons the transfer; a memory response arriving after reset is ignored.
- FSM IDLE -> REQ -> WAIT_RESP -> STREAM -> (REQ | DONE) -> IDLE.
- IDLE, start=1:
  - base_addr[2:0]!=0: pulse error next cycle, stay IDLE.
  - byte_count==0: go to DONE; done pulses one cycle after start; no bus traffic.
  - Otherwise: latch addr=base_addr and remaining=byte_count, go to REQ.
- IDLE, start=0: no action. start outside IDLE is ignored.
- REQ:
  - mem_req_valid=1, mem_req_addr=addr.
  - Valid, addr held stable until mem_req_ready=1.
  - On handshake go to WAIT_RESP and set addr <= addr+WORD_BYTES, wrapping modulo 2^ADDR_W.
- WAIT_RESP:
  - On mem_resp_valid, latch mem_resp_data into the word buffer, set byte index=0, go to STREAM.
  - No timeout.
  - Only one request is ever outstanding.
- STREAM:
  - out_valid=1; out_data = buffer[8*idx+7 : 8*idx], little-endian (byte 0 = bits 7:0).
  - out_last=1 when remaining==1.
  - On out_valid && out_ready: remaining--, idx++.
    - remaining reaches 0: go to DONE.
    - Else idx wraps past WORD_BYTES-1: go to REQ.
  - Data and last held stable while out_ready=0.
- Latency per word: 1 cycle in REQ (if ready), then response latency, then WORD_BYTES cycles at full throughput. No prefetch.
- DONE: pulse done for one cycle, clear busy, return to IDLE next cycle.
- Partial final word: only the remaining bytes are emitted; the upper bytes of the buffer are discarded.
- Invariant: mem_req_valid and out_valid are never high together.

Decomposition:
- Shared package (alongside the memory-bus definitions): memory_dump_state_t enum, WORD_BYTES, ADDR_W, and CODE_SEGMENT_START / DATA_SEGMENT_START as dump base presets.
- One natural sub-module, dump_word_serializer: word buffer, byte index, out_* handshake, and a word-consumed flag.
- Request sequencing and FSM stay in the top.

Test Plan:
- Bus preloaded with 0x0807060504030201 at 0x000100; start, base=0x000100, count=8, out_ready=1 -> bytes 01..08 on 8 consecutive cycles, last on byte 08, done 1 cycle later, exactly 1 request.
- count=11 at base 0x000200 -> 2 requests (0x200, 0x208); 11 bytes; last on the 3rd byte of word 2; done pulses once.
- out_ready toggled 1,0,0,1 during STREAM -> out_data/out_last stable while stalled; no byte lost or duplicated.
- base=0x000103 -> error pulse, no mem_req_valid, busy stays 0; count=0 at aligned base -> done with no request.
- base=0x1FFFF8, count=16 -> second request address 0x000000 (wrap).
- reset asserted during WAIT_RESP, response arrives 2 cycles later -> all outputs 0, state IDLE, response ignored; a subsequent start works normally.

Source files
------------

// File: rtl/memory_dump_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_dump_unit_pkg
// Description : Shared definitions for the memory dump unit. Holds the
//               physical memory bus geometry, the dump FSM state encoding
//               and the base-address presets for the code and data segments.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_dump_unit_pkg;

    // Physical memory bus geometry
    localparam int ADDR_W     = 21;
    localparam int WORD_BYTES = 8;
    localparam int DATA_W     = 8 * WORD_BYTES;

    typedef logic [ADDR_W-1:0] phys_memory_address_t;

    // Dump base presets: the segment bases the image loader writes to
    localparam phys_memory_address_t CODE_SEGMENT_START = 21'h000100;
    localparam phys_memory_address_t DATA_SEGMENT_START = 21'h000200;

    // Dump sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_STREAM    = 3'd3,
        ST_DONE      = 3'd4
    } memory_dump_state_t;

endpackage
`default_nettype wire

// File: rtl/dump_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : dump_word_serializer
// Description : Holds one memory-bus response word and emits it one byte at
//               a time, least significant byte first, over a valid/ready
//               byte stream. Reports each accepted byte and the acceptance of
//               the last byte lane of the word.
// Revision    : 1.0 - initial release
// ============================================================================
module dump_word_serializer #(
    parameter int WORD_BYTES = 8,
    parameter int DATA_W     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              stream_en,
    input  logic              last_byte,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              byte_fire,
    output logic              word_consumed
);

    localparam int c_idx_w = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WORD_BYTES - 1);

    logic [DATA_W-1:0]  r_word;
    logic [c_idx_w-1:0] r_idx;
    logic [DATA_W-1:0]  w_shifted;

    // Little-endian lane select: byte lane idx lives at bits [8*idx+7 : 8*idx]
    assign w_shifted     = r_word >> {r_idx, 3'b000};

    assign out_valid     = stream_en;
    assign out_data      = stream_en ? w_shifted[7:0] : 8'h00;
    assign out_last      = stream_en & last_byte;
    assign byte_fire     = stream_en & out_ready;
    assign word_consumed = byte_fire & (r_idx == c_last_idx);

    // Word buffer capture and byte-lane index advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (load) begin
            r_word <= load_data;
            r_idx  <= '0;
        end else if (byte_fire) begin
            r_idx  <= word_consumed ? '0 : r_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : memory_dump_unit
// Description : Reads a contiguous, word-aligned region of physical memory
//               over the memory bus, one outstanding read at a time, and
//               emits it as a little-endian byte stream with a last marker.
//               Misaligned starts are rejected with an error pulse; empty
//               dumps complete immediately without bus traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_dump_unit #(
    parameter int ADDR_W     = memory_dump_unit_pkg::ADDR_W,
    parameter int WORD_BYTES = memory_dump_unit_pkg::WORD_BYTES,
    parameter int DATA_W     = memory_dump_unit_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] byte_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);

    import memory_dump_unit_pkg::*;

    localparam int c_off_w = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [ADDR_W-1:0] c_word_step = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);

    memory_dump_state_t r_state;
    memory_dump_state_t w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_error;

    logic w_misaligned;
    logic w_empty;
    logic w_start_idle;
    logic w_req_fire;
    logic w_load;
    logic w_stream;
    logic w_last_byte;
    logic w_byte_fire;
    logic w_word_consumed;

    assign w_misaligned = (base_addr[c_off_w-1:0] != '0);
    assign w_empty      = (byte_count == '0);
    assign w_start_idle = start & (r_state == ST_IDLE);
    assign w_req_fire   = (r_state == ST_REQ) & mem_req_ready;
    assign w_load       = (r_state == ST_WAIT_RESP) & mem_resp_valid;
    assign w_stream     = (r_state == ST_STREAM);
    assign w_last_byte  = (r_remaining == c_one);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one read outstanding, no prefetch
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !w_misaligned) begin
                    w_state_next = w_empty ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    w_state_next = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_byte_fire) begin
                    if (w_last_byte) begin
                        w_state_next = ST_DONE;
                    end else if (w_word_consumed) begin
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Read address, remaining byte count and misalignment error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_error     <= 1'b0;
        end else begin
            r_error <= w_start_idle & w_misaligned;
            if (w_start_idle && !w_misaligned && !w_empty) begin
                r_addr      <= base_addr;
                r_remaining <= byte_count;
            end else begin
                // Address wraps modulo 2^ADDR_W through natural overflow
                if (w_req_fire) begin
                    r_addr <= r_addr + c_word_step;
                end
                if (w_byte_fire) begin
                    r_remaining <= r_remaining - c_one;
                end
            end
        end
    end

    dump_word_serializer #(
        .WORD_BYTES (WORD_BYTES),
        .DATA_W     (DATA_W)
    ) u_serializer (
        .clk           (clk),
        .reset         (reset),
        .load          (w_load),
        .load_data     (mem_resp_data),
        .stream_en     (w_stream),
        .last_byte     (w_last_byte),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .byte_fire     (w_byte_fire),
        .word_consumed (w_word_consumed)
    );

    assign busy          = (r_state == ST_REQ) | (r_state == ST_WAIT_RESP) | (r_state == ST_STREAM);
    assign done          = (r_state == ST_DONE);
    assign error         = r_error;
    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_req_addr  = (r_state == ST_REQ) ? r_addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_memory_dump_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_memory_dump_unit
// Description : Self-checking bench for memory_dump_unit. A behavioural
//               memory bus answers reads from a sparse memory image; expected
//               request addresses and stream bytes are queued when a dump is
//               started and compared as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_dump_unit;

    import memory_dump_unit_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] byte_count;
    logic              busy;
    logic              done;
    logic              error;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;

    memory_dump_unit #(
        .ADDR_W     (ADDR_W),
        .WORD_BYTES (WORD_BYTES),
        .DATA_W     (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .byte_count     (byte_count),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_byte_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } pend_t;

    exp_byte_t         byte_q[$];
    logic [ADDR_W-1:0] req_q[$];
    pend_t             pend_q[$];
    logic [DATA_W-1:0] mem[logic [ADDR_W-1:0]];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   resp_lat = 2;
    bit   ready_rand = 1'b0;
    bit   rdy_toggle = 1'b0;
    logic [3:0] rdy_bits = 4'b1001;   // out_ready sequence 1,0,0,1

    int done_cnt, err_cnt, req_cnt, busy_cnt, fire_cnt;
    int first_fire_cyc, last_fire_cyc, done_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory image: explicit preloads, otherwise an address-derived pattern
    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {11'h5A5, a, 11'h3C3, ~a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory bus model and stream consumer: drives inputs just after the edge
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        out_ready      = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready  = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready      = rdy_toggle ? rdy_bits[cyc % 4] : 1'b1;
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = word_at(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
        end
    end

    // Monitor / scoreboard: samples DUT outputs on the falling edge
    always @(negedge clk) begin : mon
        exp_byte_t e;
        if (!reset) begin
            if (mem_req_valid || out_valid)
                chk("req_out_exclusive", {63'd0, mem_req_valid & out_valid}, 64'd0);
            if (busy)  busy_cnt++;
            if (error) err_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_req_valid && !mem_req_ready && req_q.size() > 0)
                chk("req_addr_hold", {43'd0, mem_req_addr}, {43'd0, req_q[0]});
            if (mem_req_valid && mem_req_ready) begin
                req_cnt++;
                if (req_q.size() == 0) chk("extra_req", 64'd1, 64'd0);
                else chk("req_addr", {43'd0, mem_req_addr}, {43'd0, req_q.pop_front()});
                pend_q.push_back('{mem_req_addr, cyc + 1 + resp_lat});
            end
            if (out_valid && byte_q.size() == 0) begin
                chk("extra_byte", 64'd1, 64'd0);
            end else if (out_valid) begin
                e = byte_q[0];
                if (out_ready) begin
                    chk("out_data", {56'd0, out_data}, {56'd0, e.data});
                    chk("out_last", {63'd0, out_last}, {63'd0, e.last});
                    void'(byte_q.pop_front());
                    if (fire_cnt == 0) first_fire_cyc = cyc;
                    last_fire_cyc = cyc;
                    fire_cnt++;
                end else begin
                    chk("stall_data", {56'd0, out_data}, {56'd0, e.data});
                    chk("stall_last", {63'd0, out_last}, {63'd0, e.last});
                end
            end
        end
    end

    // Queue the expected traffic for one dump, start it and wait for the end
    task automatic run_dump(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt, input string tag);
        bit                misaligned;
        int                n;
        int                t;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        misaligned = (base[2:0] != 3'd0);
        n          = int'(cnt);
        done_cnt = 0; err_cnt = 0; req_cnt = 0; busy_cnt = 0; fire_cnt = 0;
        if (!misaligned) begin
            for (int w = 0; w * WORD_BYTES < n; w++)
                req_q.push_back(base + ADDR_W'(w * WORD_BYTES));
            for (int i = 0; i < n; i++) begin
                wa = base + ADDR_W'((i / WORD_BYTES) * WORD_BYTES);
                wd = word_at(wa);
                byte_q.push_back('{wd[8*(i % WORD_BYTES) +: 8], (i == n - 1)});
            end
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; byte_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_error_pulse"}, {63'd0, error}, {63'd0, misaligned});
        chk({tag, "_busy_after_start"}, {63'd0, busy}, {63'd0, !misaligned && n != 0});
        chk({tag, "_done_immediate"}, {63'd0, done}, {63'd0, !misaligned && n == 0});
        if (misaligned) begin
            repeat (6) @(negedge clk);
        end else begin
            t = 0;
            while (done_cnt == 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            repeat (3) @(negedge clk);
        end
        chk({tag, "_done_count"}, 64'(done_cnt), misaligned ? 64'd0 : 64'd1);
        chk({tag, "_error_count"}, 64'(err_cnt), misaligned ? 64'd1 : 64'd0);
        chk({tag, "_req_count"}, 64'(req_cnt), misaligned ? 64'd0 : 64'((n + WORD_BYTES - 1) / WORD_BYTES));
        chk({tag, "_bytes_left"}, 64'(byte_q.size()), 64'd0);
        chk({tag, "_reqs_left"}, 64'(req_q.size()), 64'd0);
        if (misaligned)
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd0);
        if (!misaligned && n > 0)
            chk({tag, "_done_latency"}, 64'(done_cyc - last_fire_cyc), 64'd1);
        byte_q.delete();
        req_q.delete();
    endtask

    initial begin : main
        int t;
        reset = 1'b1; start = 1'b0; base_addr = '0; byte_count = '0;
        mem[CODE_SEGMENT_START] = 64'h0807060504030201;
        repeat (2) @(negedge clk);
        chk("rst_busy",      {63'd0, busy},          64'd0);
        chk("rst_done",      {63'd0, done},          64'd0);
        chk("rst_error",     {63'd0, error},         64'd0);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_req_addr",  {43'd0, mem_req_addr},  64'd0);
        chk("rst_out_valid", {63'd0, out_valid},     64'd0);
        chk("rst_out_data",  {56'd0, out_data},      64'd0);
        chk("rst_out_last",  {63'd0, out_last},      64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single full word at full throughput
        run_dump(CODE_SEGMENT_START, 21'd8, "t1");
        chk("t1_throughput", 64'(last_fire_cyc - first_fire_cyc), 64'd7);

        // Partial second word
        run_dump(DATA_SEGMENT_START, 21'd11, "t2");

        // Consumer backpressure
        rdy_toggle = 1'b1;
        run_dump(21'h000400, 21'd13, "t3");
        rdy_toggle = 1'b0;

        // Misaligned start and empty dump
        run_dump(21'h000103, 21'd8, "t4a");
        run_dump(21'h000300, 21'd0, "t4b");

        // Address wrap at top of memory
        run_dump(21'h1FFFF8, 21'd16, "t5");

        // Bus request backpressure and longer response latency
        ready_rand = 1'b1; resp_lat = 4;
        run_dump(21'h000800, 21'd20, "t6");
        ready_rand = 1'b0; resp_lat = 2;

        // Reset while waiting for a response; the response lands afterwards
        req_cnt = 0; done_cnt = 0;
        req_q.push_back(21'h000600);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 21'h000600; byte_count = 21'd8;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (req_cnt == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("t7_req_seen", 64'(req_cnt), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t7_rst_busy",      {63'd0, busy},          64'd0);
        chk("t7_rst_done",      {63'd0, done},          64'd0);
        chk("t7_rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("t7_rst_out_valid", {63'd0, out_valid},     64'd0);
        chk("t7_rst_out_data",  {56'd0, out_data},      64'd0);
        chk("t7_rst_out_last",  {63'd0, out_last},      64'd0);
        byte_q.delete();
        req_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("t7_resp_delivered", 64'(pend_q.size()), 64'd0);
        chk("t7_idle_busy",      {63'd0, busy},      64'd0);
        chk("t7_idle_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t7_no_done",        64'(done_cnt),      64'd0);

        // Normal operation after the abandoned dump
        run_dump(CODE_SEGMENT_START, 21'd8, "t8");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
